// File: rtl/alu_pkg.sv
// Shared ALU encodings: control codes, ALU op and funct fields, default widths,
// and the decoder result payload.
package alu_pkg;

  localparam int unsigned XLEN_DEFAULT   = 32;
  localparam int unsigned REG_AW_DEFAULT = 5;
  localparam int unsigned CTL_W          = 3;
  localparam int unsigned ALUOP_W        = 2;
  localparam int unsigned FUNCT_W        = 6;
  localparam int unsigned SHAMT_W        = 5;

  localparam logic [CTL_W-1:0] CTL_AND = 3'b000;
  localparam logic [CTL_W-1:0] CTL_OR  = 3'b001;
  localparam logic [CTL_W-1:0] CTL_ADD = 3'b010;
  localparam logic [CTL_W-1:0] CTL_SUB = 3'b110;
  localparam logic [CTL_W-1:0] CTL_SLT = 3'b111;

  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [ALUOP_W-1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [ALUOP_W-1:0] ALUOP_RSVD  = 2'b11;

  localparam logic [FUNCT_W-1:0] FUNCT_ADD = 6'b100000;
  localparam logic [FUNCT_W-1:0] FUNCT_SUB = 6'b100010;
  localparam logic [FUNCT_W-1:0] FUNCT_AND = 6'b100100;
  localparam logic [FUNCT_W-1:0] FUNCT_OR  = 6'b100101;
  localparam logic [FUNCT_W-1:0] FUNCT_SLT = 6'b101010;

  typedef struct packed {
    logic [CTL_W-1:0] ctl;
    logic             illegal;
  } dec_t;

endpackage

// File: rtl/alu_ctl_decode.sv
// Combinational ALU op / funct to 3-bit ALU control decode; undecodable
// combinations fall back to add and raise illegal.
module alu_ctl_decode
  import alu_pkg::*;
(
  input  logic [ALUOP_W-1:0] aluop,
  input  logic [FUNCT_W-1:0] funct,
  output dec_t               dec_c
);

  always_comb begin
    dec_c = '{ctl: CTL_ADD, illegal: 1'b0};
    case (aluop)
      ALUOP_ADD: dec_c.ctl = CTL_ADD;
      ALUOP_SUB: dec_c.ctl = CTL_SUB;
      ALUOP_RTYPE: begin
        case (funct)
          FUNCT_ADD: dec_c.ctl = CTL_ADD;
          FUNCT_SUB: dec_c.ctl = CTL_SUB;
          FUNCT_AND: dec_c.ctl = CTL_AND;
          FUNCT_OR:  dec_c.ctl = CTL_OR;
          FUNCT_SLT: dec_c.ctl = CTL_SLT;
          default:   dec_c.illegal = 1'b1;
        endcase
      end
      default: dec_c.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage in front of the ALU: decode, operand select, issue and output
// registers. ALU_ISSUE_FWD_EN selects forwarding; otherwise hazards stall.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEFAULT,
  parameter int unsigned REG_AW = REG_AW_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ALUOP_W-1:0] in_aluop,
  input  logic [FUNCT_W-1:0] in_funct,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [REG_AW-1:0]  in_rs_idx,
  input  logic [REG_AW-1:0]  in_rt_idx,
  input  logic [REG_AW-1:0]  in_rd_idx,
  input  logic [XLEN-1:0]    in_rs_val,
  input  logic [XLEN-1:0]    in_rt_val,
  input  logic [XLEN-1:0]    in_imm,
  input  logic               in_use_imm,
  output logic [CTL_W-1:0]   alu_ctl,
  output logic [XLEN-1:0]    alu_a,
  output logic [XLEN-1:0]    alu_b,
  output logic [SHAMT_W-1:0] alu_shamt,
  input  logic [XLEN-1:0]    alu_result,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_result,
  output logic [REG_AW-1:0]  out_rd,
  output logic               illegal_op
);

  logic              iss_valid;
  logic [REG_AW-1:0] iss_rd;
  logic              adv;
  logic              stall;
  logic              accept;
  logic              move;
  logic              rs_iss_hit;
  logic              rs_out_hit;
  logic              rt_iss_hit;
  logic              rt_out_hit;
  logic [XLEN-1:0]   op_a;
  logic [XLEN-1:0]   rt_sel;
  logic [XLEN-1:0]   op_b;
  dec_t              dec;

  alu_ctl_decode u_dec (
    .aluop (in_aluop),
    .funct (in_funct),
    .dec_c (dec)
  );

  // Source-index matches against in-flight destinations; index 0 never matches.
  always_comb begin
    rs_iss_hit = iss_valid && (in_rs_idx != '0) && (in_rs_idx == iss_rd);
    rs_out_hit = out_valid && (in_rs_idx != '0) && (in_rs_idx == out_rd);
    rt_iss_hit = iss_valid && (in_rt_idx != '0) && (in_rt_idx == iss_rd);
    rt_out_hit = out_valid && (in_rt_idx != '0) && (in_rt_idx == out_rd);
  end

`ifdef ALU_ISSUE_FWD_EN
  // Youngest producer wins: the issue register's live ALU result, then OUT.
  always_comb begin
    stall  = 1'b0;
    op_a   = in_rs_val;
    rt_sel = in_rt_val;
    if (rs_iss_hit)      op_a = alu_result;
    else if (rs_out_hit) op_a = out_result;
    if (rt_iss_hit)      rt_sel = alu_result;
    else if (rt_out_hit) rt_sel = out_result;
  end
`else
  // Without forwarding, hold off until the producer has left OUT.
  always_comb begin
    stall  = in_valid && (rs_iss_hit || rs_out_hit ||
                          (!in_use_imm && (rt_iss_hit || rt_out_hit)));
    op_a   = in_rs_val;
    rt_sel = in_rt_val;
  end
`endif

  assign op_b     = in_use_imm ? in_imm : rt_sel;
  assign adv      = !out_valid || out_ready;
  assign in_ready = (!iss_valid || adv) && !stall;
  assign accept   = in_valid && in_ready;
  assign move     = iss_valid && adv;

  always_ff @(posedge clk) begin
    if (rst) begin
      iss_valid  <= 1'b0;
      iss_rd     <= '0;
      alu_ctl    <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_shamt  <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_rd     <= '0;
      illegal_op <= 1'b0;
    end else begin
      illegal_op <= accept && dec.illegal;
      if (accept) begin
        iss_rd    <= in_rd_idx;
        alu_ctl   <= dec.ctl;
        alu_a     <= op_a;
        alu_b     <= op_b;
        alu_shamt <= in_shamt;
      end
      if (accept)    iss_valid <= 1'b1;
      else if (move) iss_valid <= 1'b0;
      // Simultaneous drain and refill keeps OUT occupied.
      if (move) begin
        out_result <= alu_result;
        out_rd     <= iss_rd;
        out_valid  <= 1'b1;
      end else if (out_ready) begin
        out_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: architectural register-file model,
// directed scenarios, then randomized traffic with random downstream stalls.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_aluop = '0;
  logic [5:0]  in_funct = '0;
  logic [4:0]  in_shamt = '0;
  logic [4:0]  in_rs_idx = '0;
  logic [4:0]  in_rt_idx = '0;
  logic [4:0]  in_rd_idx = '0;
  logic [31:0] in_rs_val = '0;
  logic [31:0] in_rt_val = '0;
  logic [31:0] in_imm = '0;
  logic        in_use_imm = 1'b0;
  logic [2:0]  alu_ctl;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  alu_shamt;
  logic [31:0] alu_result;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        illegal_op;

  alu_issue_stage #(.XLEN(32), .REG_AW(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_aluop(in_aluop), .in_funct(in_funct), .in_shamt(in_shamt),
    .in_rs_idx(in_rs_idx), .in_rt_idx(in_rt_idx), .in_rd_idx(in_rd_idx),
    .in_rs_val(in_rs_val), .in_rt_val(in_rt_val),
    .in_imm(in_imm), .in_use_imm(in_use_imm),
    .alu_ctl(alu_ctl), .alu_a(alu_a), .alu_b(alu_b), .alu_shamt(alu_shamt),
    .alu_result(alu_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd),
    .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  // Attached 32-bit ALU.
  always_comb begin
    case (alu_ctl)
      3'b000:  alu_result = alu_a & alu_b;
      3'b001:  alu_result = alu_a | alu_b;
      3'b110:  alu_result = alu_a - alu_b;
      3'b111:  alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      default: alu_result = alu_a + alu_b;
    endcase
  end

`ifdef ALU_ISSUE_FWD_EN
  localparam int EXP_DEP_WAITS = 0;
`else
  localparam int EXP_DEP_WAITS = 2;
`endif

  typedef struct {
    logic [1:0]  aluop;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] rs0;
    logic [31:0] rt0;
    logic [31:0] imm;
    logic        use_imm;
  } instr_t;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
  } exp_t;

  int          n_checks = 0;
  int          n_fail = 0;
  int          or_mode = 0;
  exp_t        q[$];
  logic [31:0] rf_arch [32];
  logic [31:0] rf_ret  [32];

  bit          acc_now = 1'b0;
  logic [2:0]  acc_ctl;
  logic [31:0] acc_a;
  logic [31:0] acc_b;
  logic [4:0]  acc_shamt;
  bit          acc_ill;
  logic [2:0]  hold_ctl = '0;
  logic [31:0] hold_a = '0;
  logic [31:0] hold_b = '0;
  logic [4:0]  hold_shamt = '0;
  bit          exp_ill = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction semantics straight from the op/funct table.
  task automatic ref_exec(input instr_t i, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic [2:0] ctl, output bit ill);
    ill = 1'b0;
    ctl = 3'b010;
    res = a + b;
    if (i.aluop == 2'b01) begin
      ctl = 3'b110; res = a - b;
    end else if (i.aluop == 2'b10) begin
      case (i.funct)
        6'b100000: begin ctl = 3'b010; res = a + b; end
        6'b100010: begin ctl = 3'b110; res = a - b; end
        6'b100100: begin ctl = 3'b000; res = a & b; end
        6'b100101: begin ctl = 3'b001; res = a | b; end
        6'b101010: begin ctl = 3'b111; res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
        default:   ill = 1'b1;
      endcase
    end else if (i.aluop == 2'b11) begin
      ill = 1'b1;
    end
  endtask

  function automatic bit busy(input logic [4:0] idx);
    if (idx == 5'd0) return 1'b0;
    foreach (q[k]) if (q[k].rd == idx) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit stall_model(input instr_t i);
`ifdef ALU_ISSUE_FWD_EN
    return (i.rs == 5'd0) && (i.rs != 5'd0);
`else
    return busy(i.rs) || (!i.use_imm && busy(i.rt));
`endif
  endfunction

  function automatic instr_t mk(input logic [1:0] op, input logic [5:0] fn, input logic [4:0] rs,
                                input logic [4:0] rt, input logic [4:0] rd,
                                input logic [31:0] imm, input logic use_imm);
    instr_t i;
    i.aluop = op; i.funct = fn; i.shamt = 5'd0; i.rs = rs; i.rt = rt; i.rd = rd;
    i.rs0 = 32'd0; i.rt0 = 32'd0; i.imm = imm; i.use_imm = use_imm;
    return i;
  endfunction

  function automatic instr_t rand_instr();
    instr_t      i;
    int unsigned sel;
    sel = $urandom_range(0, 9);
    i.aluop = (sel < 2) ? 2'b00 : (sel < 4) ? 2'b01 : (sel < 9) ? 2'b10 : 2'b11;
    case ($urandom_range(0, 5))
      0:       i.funct = 6'b100000;
      1:       i.funct = 6'b100010;
      2:       i.funct = 6'b100100;
      3:       i.funct = 6'b100101;
      4:       i.funct = 6'b101010;
      default: i.funct = 6'($urandom);
    endcase
    i.shamt   = 5'($urandom);
    i.rs      = 5'($urandom_range(0, 7));
    i.rt      = 5'($urandom_range(0, 7));
    i.rd      = 5'($urandom_range(0, 7));
    i.rs0     = $urandom;
    i.rt0     = $urandom;
    i.imm     = $urandom;
    i.use_imm = 1'($urandom_range(0, 1));
    return i;
  endfunction

  // Register-file read data comes from retired state only.
  task automatic drive(input instr_t i);
    in_valid   = 1'b1;
    in_aluop   = i.aluop;
    in_funct   = i.funct;
    in_shamt   = i.shamt;
    in_rs_idx  = i.rs;
    in_rt_idx  = i.rt;
    in_rd_idx  = i.rd;
    in_rs_val  = (i.rs == 5'd0) ? i.rs0 : rf_ret[i.rs];
    in_rt_val  = (i.rt == 5'd0) ? i.rt0 : rf_ret[i.rt];
    in_imm     = i.imm;
    in_use_imm = i.use_imm;
  endtask

  task automatic issue(input instr_t ins, input int max_wait, output int waits, output bit acc);
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [2:0]  ctl;
    bit          ill;
    bit          exp_rdy;
    waits = 0;
    acc = 1'b0;
    forever begin
      @(negedge clk);
      drive(ins);
      #1;
      exp_rdy = ((q.size() < 2) || out_ready) && !stall_model(ins);
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      if (in_ready) begin
        a = (ins.rs == 5'd0) ? ins.rs0 : rf_arch[ins.rs];
        b = ins.use_imm ? ins.imm : ((ins.rt == 5'd0) ? ins.rt0 : rf_arch[ins.rt]);
        ref_exec(ins, a, b, res, ctl, ill);
        if (ins.rd != 5'd0) rf_arch[ins.rd] = res;
        q.push_back('{res: res, rd: ins.rd});
        acc_ctl = ctl; acc_a = a; acc_b = b; acc_shamt = ins.shamt; acc_ill = ill;
        acc_now = 1'b1;
        acc = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        break;
      end
      if (waits >= max_wait) break;
      waits++;
    end
  endtask

  task automatic issue_ok(input instr_t ins, output int waits);
    bit acc;
    issue(ins, 50, waits, acc);
    chk("issue_accepted", 32'(acc), 32'd1);
  endtask

  task automatic set_or(input int mode);
    or_mode = mode;
    @(posedge clk);
    #2;
  endtask

  task automatic drain();
    int n;
    or_mode = 1;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      #4;
      n++;
    end
    chk("drain_empty", 32'(q.size()), 32'd0);
  endtask

  task automatic set_reg(input int r, input logic [31:0] v);
    rf_arch[r] = v;
    rf_ret[r]  = v;
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    q.delete();
    rf_arch = rf_ret;
    hold_ctl = '0; hold_a = '0; hold_b = '0; hold_shamt = '0;
    exp_ill = 1'b0;
    acc_now = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_out_rd", 32'(out_rd), 32'd0);
  endtask

  // Downstream ready: 0 = stalled, 1 = always ready, else random.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (or_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Output monitor: pops the scoreboard on every writeback transfer.
  initial begin : mon
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_output", 32'(out_valid), 32'd0);
        end else begin
          e = q.pop_front();
          chk("out_result", out_result, e.res);
          chk("out_rd", 32'(out_rd), 32'(e.rd));
          if (e.rd != 5'd0) rf_ret[e.rd] = e.res;
        end
      end
    end
  end

  // Issue-register checker: alu_* hold last accepted values, illegal_op pulses once.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (!rst) begin
        chk("alu_ctl", 32'(alu_ctl), 32'(hold_ctl));
        chk("alu_a", alu_a, hold_a);
        chk("alu_b", alu_b, hold_b);
        chk("alu_shamt", 32'(alu_shamt), 32'(hold_shamt));
        chk("illegal_op", 32'(illegal_op), 32'(exp_ill));
      end
      if (acc_now) begin
        hold_ctl = acc_ctl; hold_a = acc_a; hold_b = acc_b; hold_shamt = acc_shamt;
      end
      exp_ill = acc_now && acc_ill;
      acc_now = 1'b0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int     w;
    bit     acc;
    instr_t ins;
    for (int r = 0; r < 32; r++) begin
      rf_ret[r] = $urandom;
      rf_arch[r] = rf_ret[r];
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("init_in_ready", 32'(in_ready), 32'd1);
    chk("init_out_valid", 32'(out_valid), 32'd0);
    chk("init_out_result", out_result, 32'd0);
    chk("init_out_rd", 32'(out_rd), 32'd0);
    chk("init_illegal", 32'(illegal_op), 32'd0);
    set_or(1);

    // R-type sweep with rs=7, rt=3.
    set_reg(10, 32'd7);
    set_reg(11, 32'd3);
    issue_ok(mk(2'b10, 6'b100000, 5'd10, 5'd11, 5'd12, 32'd0, 1'b0), w);
    issue_ok(mk(2'b10, 6'b100010, 5'd10, 5'd11, 5'd13, 32'd0, 1'b0), w);
    issue_ok(mk(2'b10, 6'b100100, 5'd10, 5'd11, 5'd14, 32'd0, 1'b0), w);
    issue_ok(mk(2'b10, 6'b100101, 5'd10, 5'd11, 5'd15, 32'd0, 1'b0), w);
    issue_ok(mk(2'b10, 6'b101010, 5'd10, 5'd11, 5'd16, 32'd0, 1'b0), w);
    drain();

    // Back-to-back dependency: r1 = 5 + 6, then r4 = r1 + 1.
    set_reg(1, 32'd0);
    set_reg(2, 32'd5);
    set_reg(3, 32'd6);
    issue_ok(mk(2'b00, 6'd0, 5'd2, 5'd3, 5'd1, 32'd0, 1'b0), w);
    issue_ok(mk(2'b00, 6'd0, 5'd1, 5'd0, 5'd4, 32'd1, 1'b1), w);
    chk("dep_wait_cycles", 32'(w), 32'(EXP_DEP_WAITS));
    drain();

    // Index 0: rd=0 producer, rs=0 consumer with in_rs_val=0.
    issue_ok(mk(2'b00, 6'd0, 5'd2, 5'd3, 5'd0, 32'd0, 1'b0), w);
    issue_ok(mk(2'b00, 6'd0, 5'd0, 5'd3, 5'd5, 32'd0, 1'b0), w);
    chk("idx0_wait_cycles", 32'(w), 32'd0);
    drain();

    // Illegal funct still completes as an add.
    issue_ok(mk(2'b10, 6'b111111, 5'd2, 5'd3, 5'd6, 32'd0, 1'b0), w);
    drain();

    // Back-pressure: third instruction held while downstream stalls.
    set_or(0);
    issue_ok(mk(2'b00, 6'd0, 5'd2, 5'd3, 5'd7, 32'd0, 1'b0), w);
    issue_ok(mk(2'b01, 6'd0, 5'd2, 5'd3, 5'd8, 32'd0, 1'b0), w);
    ins = mk(2'b10, 6'b100101, 5'd10, 5'd11, 5'd9, 32'd0, 1'b0);
    issue(ins, 3, w, acc);
    chk("bp_third_held", 32'(acc), 32'd0);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    or_mode = 1;
    issue_ok(ins, w);
    drain();

    // Reset mid-stream with both slots full.
    set_or(0);
    issue_ok(mk(2'b00, 6'd0, 5'd2, 5'd3, 5'd17, 32'd0, 1'b0), w);
    issue_ok(mk(2'b00, 6'd0, 5'd10, 5'd11, 5'd18, 32'd0, 1'b0), w);
    do_reset();
    set_or(1);

    // Randomized traffic with random downstream back-pressure.
    or_mode = 2;
    for (int n = 0; n < 300; n++) begin
      issue_ok(rand_instr(), w);
      if ($urandom_range(0, 7) == 0) begin
        @(negedge clk);
      end
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
